// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment driver: refresh timer, digit scan,
// hex decode, anti-ghost blanking, leading-zero blanking and frame-synced load.
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 16,
  parameter int HEX    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   in_num_i,
  input  logic [DIGITS-1:0]     dp_en_i,
  input  logic                  load_i,
  input  logic [DIGITS-1:0]     digit_en_i,
  input  logic                  lz_blank_i,
  output logic [7:0]            out_led_o,
  output logic [DIGITS-1:0]     arrange_o,
  output logic                  frame_done_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    disp_num_q, disp_num_d;
  logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0]    pend_num_q, pend_num_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [7:0]             out_led_q, out_led_d;
  logic [DIGITS-1:0]      arrange_q, arrange_d;
  logic                   frame_done_q, frame_done_d;

  logic                   slot_end, boundary, active;
  logic [3:0]             cur_nib;
  logic                   cur_dp, cur_en, cur_lz;
  logic [DIGITS-1:0]      lz_vec;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = (HEX != 0) ? 7'b0001000 : 7'b1111111;
      4'hB: seg = (HEX != 0) ? 7'b1100000 : 7'b1111111;
      4'hC: seg = (HEX != 0) ? 7'b0110001 : 7'b1111111;
      4'hD: seg = (HEX != 0) ? 7'b1000010 : 7'b1111111;
      4'hE: seg = (HEX != 0) ? 7'b0110000 : 7'b1111111;
      default: seg = (HEX != 0) ? 7'b0111000 : 7'b1111111;
    endcase
    return seg;
  endfunction

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    logic all_zero;
    lz_vec   = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero  = all_zero && (disp_num_q[i*4 +: 4] == 4'h0);
      lz_vec[i] = all_zero;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib = disp_num_q[i*4 +: 4];
        cur_dp  = disp_dp_q[i];
        cur_en  = digit_en_i[i];
        cur_lz  = lz_vec[i];
      end
    end
  end

  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    boundary     = slot_end && (idx_q == IDX_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    if (slot_end)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    disp_num_d   = disp_num_q;
    disp_dp_d    = disp_dp_q;
    pend_num_d   = pend_num_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    // A load landing on the boundary edge itself goes straight to the display.
    if (boundary) begin
      pend_valid_d = 1'b0;
      if (load_i) begin
        disp_num_d = in_num_i;
        disp_dp_d  = dp_en_i;
      end else if (pend_valid_q) begin
        disp_num_d = pend_num_q;
        disp_dp_d  = pend_dp_q;
      end
    end else if (load_i) begin
      pend_num_d   = in_num_i;
      pend_dp_d    = dp_en_i;
      pend_valid_d = 1'b1;
    end

    active       = (int'(cnt_q) >= BLANK) && cur_en;
    out_led_d    = 8'hFF;
    arrange_d    = '1;
    if (active) begin
      out_led_d = {((lz_blank_i && cur_lz) ? 7'h7F : decode(cur_nib)), ~cur_dp};
      for (int i = 0; i < DIGITS; i++)
        arrange_d[i] = (idx_q != IW'(i));
    end
    frame_done_d = boundary;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_num_q   <= '0;
      disp_dp_q    <= '0;
      pend_num_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      out_led_q    <= 8'hFF;
      arrange_q    <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_num_q   <= disp_num_d;
      disp_dp_q    <= disp_dp_d;
      pend_num_q   <= pend_num_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      out_led_q    <= out_led_d;
      arrange_q    <= arrange_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_led_o    = out_led_q;
  assign arrange_o    = arrange_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (DIGITS=4, DIV=8, BLANK=2) with a HEX=0 twin.
// Edge k after reset release shows the slot state cnt=(k-1)%8, idx=((k-1)/8)%4.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] inNum = 16'h0;
  logic [3:0]  dpEn = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  digitEn = 4'hF;
  logic        lzBlank = 1'b0;
  logic [7:0]  outLed, outLedH0;
  logic [3:0]  arrange, arrangeH0;
  logic        frameDone, frameDoneH0;

  int assertCount = 0;
  int failCount = 0;
  int edgeCnt = 0;
  logic maskViol;

  seg7_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK(2), .HEX(1)) dut (
    .clk_i(clk), .rst_i(rst), .in_num_i(inNum), .dp_en_i(dpEn), .load_i(load),
    .digit_en_i(digitEn), .lz_blank_i(lzBlank), .out_led_o(outLed),
    .arrange_o(arrange), .frame_done_o(frameDone));

  seg7_scan_ctrl #(.DIGITS(4), .DIV(8), .BLANK(2), .HEX(0)) dutHex0 (
    .clk_i(clk), .rst_i(rst), .in_num_i(inNum), .dp_en_i(dpEn), .load_i(load),
    .digit_en_i(digitEn), .lz_blank_i(lzBlank), .out_led_o(outLedH0),
    .arrange_o(arrangeH0), .frame_done_o(frameDoneH0));

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edgeCnt <= 0;
    else     edgeCnt <= edgeCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Park at the falling edge that follows posedge number k.
  task automatic runTo(input int k);
    int guard = 0;
    while (edgeCnt < k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (edgeCnt != k) checkOutput("runTo", edgeCnt, k);
  endtask

  // One-cycle load pulse sampled by posedge k.
  task automatic applyStimulus(input logic [15:0] num, input logic [3:0] dp, input int k);
    runTo(k - 1);
    inNum = num;
    dpEn  = dp;
    load  = 1'b1;
    runTo(k);
    load  = 1'b0;
  endtask

  task automatic checkDigit(input string tag, input int k, input logic [3:0] arrExp, input logic [7:0] ledExp);
    runTo(k);
    checkOutput({tag, ".arr"}, 32'(arrange), 32'(arrExp));
    checkOutput({tag, ".led"}, 32'(outLed), 32'(ledExp));
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    checkOutput("rst.led", 32'(outLed), 32'hFF);
    checkOutput("rst.arr", 32'(arrange), 32'hF);
    checkOutput("rst.fd", 32'(frameDone), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Scan order and blanking after reset release
    checkDigit("blank1", 1, 4'hF, 8'hFF);
    checkDigit("blank2", 2, 4'hF, 8'hFF);
    checkDigit("dig0first", 3, 4'hE, 8'h03);
    checkDigit("dig0last", 8, 4'hE, 8'h03);
    checkDigit("dig1blank", 9, 4'hF, 8'hFF);
    checkDigit("dig1", 11, 4'hD, 8'h03);
    checkDigit("dig2", 19, 4'hB, 8'h03);
    checkDigit("dig3", 27, 4'h7, 8'h03);
    runTo(31); checkOutput("fd31", 32'(frameDone), 32'h0);
    runTo(32); checkOutput("fd32", 32'(frameDone), 32'h1);
    runTo(33); checkOutput("fd33", 32'(frameDone), 32'h0);

    // Decode and decimal point, loaded mid-frame
    checkDigit("f1d0old", 35, 4'hE, 8'h03);
    applyStimulus(16'hA9F0, 4'b0100, 40);
    checkDigit("f1d1old", 43, 4'hD, 8'h03);
    runTo(64); checkOutput("fd64", 32'(frameDone), 32'h1);
    checkDigit("hexD0", 67, 4'hE, 8'h03);
    checkDigit("hexD1", 75, 4'hD, 8'h71);
    checkOutput("hex0D1", 32'(outLedH0), 32'hFF);
    checkDigit("hexD2", 83, 4'hB, 8'h08);
    checkOutput("hex0D2", 32'(outLedH0), 32'h08);
    checkDigit("hexD3", 91, 4'h7, 8'h11);
    checkOutput("hex0D3", 32'(outLedH0), 32'hFF);

    // No tearing: load during digit 1 waits for next frame
    applyStimulus(16'h1234, 4'b0000, 106);
    checkDigit("tearOld", 115, 4'hB, 8'h08);
    checkDigit("tearNewD0", 131, 4'hE, 8'h99);
    checkDigit("tearNewD2", 147, 4'hB, 8'h25);

    // Load on the boundary edge lands in that very frame
    applyStimulus(16'h0012, 4'b0000, 160);
    checkDigit("bndD0", 163, 4'hE, 8'h25);
    checkDigit("bndD1", 171, 4'hD, 8'h9F);
    checkDigit("bndD3", 187, 4'h7, 8'h03);

    // Leading-zero blanking is live
    runTo(192);
    lzBlank = 1'b1;
    applyStimulus(16'h0000, 4'b1000, 200);
    checkDigit("lzD1", 203, 4'hD, 8'h9F);
    checkDigit("lzD2", 211, 4'hB, 8'hFF);
    checkDigit("lzD3", 219, 4'h7, 8'hFF);
    checkDigit("lzZeroD0", 227, 4'hE, 8'h03);
    checkDigit("lzZeroD1", 235, 4'hD, 8'hFF);
    checkDigit("lzZeroD3dp", 251, 4'h7, 8'hFE);

    // Digit mask: slots 0 and 2 stay dark, frame length unchanged
    runTo(256);
    digitEn = 4'b1010;
    lzBlank = 1'b0;
    maskViol = 1'b0;
    for (int k = 257; k <= 288; k++) begin
      runTo(k);
      if (!arrange[0] || !arrange[2]) maskViol = 1'b1;
      if (k == 259) checkOutput("maskD0.arr", 32'(arrange), 32'hF);
      if (k == 267) checkOutput("maskD1.led", 32'(outLed), 32'h03);
      if (k == 283) checkOutput("maskD3.led", 32'(outLed), 32'h02);
      if (k == 287) checkOutput("maskFd287", 32'(frameDone), 32'h0);
      if (k == 288) checkOutput("maskFd288", 32'(frameDone), 32'h1);
    end
    checkOutput("maskBits", 32'(maskViol), 32'h0);
    digitEn = 4'hF;

    // Back-to-back loads: last one wins
    applyStimulus(16'h1111, 4'b0000, 295);
    applyStimulus(16'h2222, 4'b0000, 305);
    runTo(320); checkOutput("fd320", 32'(frameDone), 32'h1);
    checkDigit("b2bD0", 323, 4'hE, 8'h25);
    checkDigit("b2bD1", 331, 4'hD, 8'h25);
    checkDigit("b2bD3", 347, 4'h7, 8'h25);

    // Reset between a load and its boundary discards it
    applyStimulus(16'h3333, 4'b1111, 360);
    runTo(365);
    rst = 1'b1;
    #1;
    checkOutput("midRst.led", 32'(outLed), 32'hFF);
    checkOutput("midRst.arr", 32'(arrange), 32'hF);
    checkOutput("midRst.fd", 32'(frameDone), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    checkDigit("postRstD0", 3, 4'hE, 8'h03);
    runTo(32); checkOutput("postRstFd", 32'(frameDone), 32'h1);
    checkDigit("postRstF1D0", 35, 4'hE, 8'h03);
    checkDigit("postRstF1D3", 59, 4'h7, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
